pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Control block that sequences the ProgramCounter register of the single-cycle RISC-V core.
- Produces `next_pc` every cycle: sequential (+4), jump, taken branch, or hold.
- Runs a boot delay after reset and stalls on instruction-memory not-ready.
- Halts on debug request or fault; counts retired instructions.
- Sits between decode/branch logic, instruction memory and the PC register.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
BOOT_CYCLES, 2, cycles spent in BOOT before first fetch (>=1)
WAIT_TIMEOUT, 16, consecutive not-ready cycles in WAIT before fetch fault (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
pc  in  32  current PC register value
imem_ready  in  1  instruction word for `pc` is valid this cycle
jump  in  1  unconditional jump (JAL/JALR) decoded
jump_target  in  32  jump destination
branch_taken  in  1  conditional branch resolved taken
branch_target  in  32  branch destination
halt_req  in  1  debug/EBREAK halt request, level
resume  in  1  single-cycle resume pulse from HALT
next_pc  out  32  value loaded into PC register at next edge
fetch_valid  out  1  current instruction retires this cycle
state  out  2  BOOT=0, RUN=1, WAIT=2, HALT=3
halted  out  1  state==HALT
fault  out  1  sticky: misaligned target or fetch timeout
instret  out  32  retired-instruction counter

Behaviour:
- Reset (sampled at posedge with reset=1) sets registered state:
  - state=BOOT, boot_cnt=0, wait_cnt=0, fault=0, instret=0.
  - While reset=1, `next_pc`=RESET_VECTOR and `fetch_valid`=0.
- `next_pc`, `fetch_valid` and `halted` are combinational from state and inputs; all other state is registered.
- Hold means `next_pc`=`pc`.
- Sequential address: `seq` = `pc`+4, 32-bit modulo (32'hFFFF_FFFC -> 32'h0000_0000).
- Target selection, in priority order: `jump` -> `jump_target`; `branch_taken` -> `branch_target`; otherwise `seq`.
- BOOT:
  - `next_pc`=RESET_VECTOR, `fetch_valid`=0.
  - boot_cnt increments each cycle.
  - When boot_cnt==BOOT_CYCLES-1, go to RUN.
- RUN, checks in priority order:
  - `halt_req`=1: hold, no retire, go to HALT.
  - `imem_ready`=0: hold, no retire, go to WAIT, wait_cnt=1.
  - Selected target has bits[1:0]!=0: hold, no retire, set fault, go to HALT.
  - Otherwise: `fetch_valid`=1, `next_pc`=selected target, instret++ (wraps modulo 2^32), stay in RUN.
- WAIT:
  - `halt_req` has priority: hold, go to HALT.
  - `imem_ready`=1: behaves exactly as RUN for this cycle (retire + target, or misalign fault), state to RUN, wait_cnt=0.
  - `imem_ready`=0: hold; wait_cnt++.
  - When wait_cnt==WAIT_TIMEOUT and still not ready: set fault, go to HALT.
- HALT:
  - Hold, `fetch_valid`=0.
  - `resume`=1 with fault=0 and `halt_req`=0: go to RUN next cycle. First fetch occurs in RUN.
  - `resume` while fault=1 is ignored; fault clears only on reset.
  - `resume` while `halt_req`=1 is ignored.
- Synchronous reset in any state at any cycle overrides all inputs and returns to BOOT.
- `jump` and `branch_taken` are ignored outside a retiring cycle.

Test Plan:
- Reset then BOOT: reset=1 for 2 cycles, release, BOOT_CYCLES=2 -> `next_pc`=0, state=BOOT for 2 cycles, then RUN; with `pc`=0 and `imem_ready`=1, `next_pc`=4, `fetch_valid`=1, instret=1.
- Redirect priority: `pc`=8, `jump`=1 to 0x40, `branch_taken`=1 to 0x80 -> `next_pc`=0x40. Next cycle: `branch_taken` only, target 0x80 -> `next_pc`=0x80. Each cycle instret increments.
- Stall and timeout:
  - `imem_ready`=0 for 3 cycles at `pc`=0x10 -> `next_pc`=0x10, state=WAIT, instret unchanged; ready=1 -> `next_pc`=0x14.
  - `imem_ready` held 0 for 16 cycles -> fault=1, state=HALT.
- Halt/resume:
  - `halt_req` at `pc`=0x20 -> HALT, `next_pc`=0x20.
  - Drop `halt_req`, pulse `resume` -> RUN next cycle; then `next_pc`=0x24.
  - `resume` with fault=1 -> stays HALT.
- Misaligned: `jump_target`=0x42 -> fault=1, HALT, `next_pc`=`pc`, instret unchanged.
- Wrap and mid-run reset: `pc`=0xFFFF_FFFC in RUN -> `next_pc`=0. Reset asserted mid-WAIT -> state=BOOT, instret=0, fault=0 at next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle RISC-V core: chooses next_pc
// each cycle and runs the BOOT / RUN / WAIT / HALT control flow around fetch.
//
// state | meaning
// BOOT  | post-reset delay, next_pc pinned to RESET_VECTOR
// RUN   | normal fetch; retires when imem is ready and the target is aligned
// WAIT  | instruction memory not ready; counts toward fetch timeout
// HALT  | debug halt or fault; PC held until resume (fault is sticky)
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          BOOT_CYCLES  = 2,
   parameter int          WAIT_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        imem_ready,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] next_pc,
   output logic        fetch_valid,
   output logic [1:0]  state,
   output logic        halted,
   output logic        fault,
   output logic [31:0] instret
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   localparam int BW = $clog2(BOOT_CYCLES) + 1;
   localparam int WW = $clog2(WAIT_TIMEOUT) + 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
   // The RUN cycle that first sees not-ready counts as miss 1, so WAIT
   // gives up on its (WAIT_TIMEOUT-1)-th not-ready cycle.
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);

   state_t         st;
   logic [BW-1:0]  boot_cnt;
   logic [WW-1:0]  wait_cnt;
   logic           fault_q;
   logic [31:0]    instret_q;

   logic [31:0]    seq_pc;
   logic [31:0]    target;
   logic           misalign;
   logic           fetch_ok;

   assign seq_pc   = pc + 32'd4;
   assign target   = jump ? jump_target : (branch_taken ? branch_target : seq_pc);
   assign misalign = (target[1:0] != 2'b00);
   assign fetch_ok = !halt_req && imem_ready && !misalign;

   always_comb begin
      next_pc     = pc;
      fetch_valid = 1'b0;
      if (reset) begin
         next_pc = RESET_VECTOR;
      end else begin
         unique case (st)
            ST_BOOT: next_pc = RESET_VECTOR;
            ST_RUN, ST_WAIT: begin
               if (fetch_ok) begin
                  next_pc     = target;
                  fetch_valid = 1'b1;
               end
            end
            ST_HALT: next_pc = pc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= ST_BOOT;
         boot_cnt  <= '0;
         wait_cnt  <= '0;
         fault_q   <= 1'b0;
         instret_q <= '0;
      end else begin
         unique case (st)
            ST_BOOT: begin
               boot_cnt <= boot_cnt + BW'(1);
               if (boot_cnt == BOOT_LAST) st <= ST_RUN;
            end
            ST_RUN: begin
               if (halt_req) begin
                  st <= ST_HALT;
               end else if (!imem_ready) begin
                  st       <= ST_WAIT;
                  wait_cnt <= WW'(1);
               end else if (misalign) begin
                  fault_q <= 1'b1;
                  st      <= ST_HALT;
               end else begin
                  instret_q <= instret_q + 32'd1;
               end
            end
            ST_WAIT: begin
               if (halt_req) begin
                  st       <= ST_HALT;
                  wait_cnt <= '0;
               end else if (imem_ready) begin
                  wait_cnt <= '0;
                  if (misalign) begin
                     fault_q <= 1'b1;
                     st      <= ST_HALT;
                  end else begin
                     instret_q <= instret_q + 32'd1;
                     st        <= ST_RUN;
                  end
               end else if (wait_cnt >= WAIT_LAST) begin
                  fault_q  <= 1'b1;
                  st       <= ST_HALT;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            ST_HALT: begin
               if (resume && !fault_q && !halt_req) st <= ST_RUN;
            end
         endcase
      end
   end

   assign state   = st;
   assign halted  = (st == ST_HALT);
   assign fault   = fault_q;
   assign instret = instret_q;

endmodule
